// File: rtl/as6d_pcs_tx_interleaver_pingpong_buf.sv
// AS6 PCS TX block interleaver: writes codeword words in natural order into one of two
// ping-pong banks and reads each full bank out column-interleaved across INTLV_DEPTH codewords.
module as6d_pcs_tx_interleaver_pingpong_buf #(
   parameter int DATA_WIDTH  = 72,
   parameter int CW_WORDS    = 8,
   parameter int INTLV_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_sof,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_sof,
   input  logic                  out_ready,
   output logic                  align_err,
   output logic [15:0]           blk_cnt
);

   localparam int CW_AW     = $clog2(CW_WORDS);
   localparam int ID_AW     = $clog2(INTLV_DEPTH);
   localparam int BLK_WORDS = CW_WORDS * INTLV_DEPTH;
   localparam int BLK_AW    = CW_AW + ID_AW;

   logic [DATA_WIDTH-1:0] mem [2][BLK_WORDS];

   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        bank_full;
   logic [1:0]        bank_full_next;
   logic [BLK_AW-1:0] wr_ptr;
   logic [BLK_AW-1:0] wr_ptr_next;
   logic [BLK_AW-1:0] wr_addr;
   logic [CW_AW-1:0]  rd_w;
   logic [ID_AW-1:0]  rd_cw;

   logic accept;
   logic misalign;
   logic wr_last;
   logic load;
   logic rd_last;

   assign in_ready = enable && !bank_full[wr_bank];
   assign accept   = in_valid && in_ready;
   // A mid-block sof restarts the block: the word lands at address 0.
   assign misalign = accept && in_sof && (wr_ptr != '0);
   assign wr_addr  = misalign ? '0 : wr_ptr;
   assign wr_last  = accept && (wr_addr == BLK_AW'(BLK_WORDS - 1));

   assign load    = enable && bank_full[rd_bank] && (!out_valid || out_ready);
   assign rd_last = load && (rd_w == CW_AW'(CW_WORDS - 1)) && (rd_cw == ID_AW'(INTLV_DEPTH - 1));

   always_comb begin
      wr_ptr_next = wr_ptr;
      if (misalign) begin
         wr_ptr_next = BLK_AW'(1);
      end else if (accept) begin
         wr_ptr_next = wr_ptr + BLK_AW'(1);
      end
   end

   // Set (write side) and clear (read side) never hit the same bank in one cycle.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_full_next[gi] = (bank_full[gi] && !(rd_last && (rd_bank == 1'(gi))))
                                || (wr_last && (wr_bank == 1'(gi)));
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_bank][wr_addr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         bank_full <= 2'b00;
         wr_ptr    <= '0;
         rd_w      <= '0;
         rd_cw     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         align_err <= 1'b0;
         blk_cnt   <= 16'd0;
      end else if (!enable) begin
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         bank_full <= 2'b00;
         wr_ptr    <= '0;
         rd_w      <= '0;
         rd_cw     <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         align_err <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_next;
         bank_full <= bank_full_next;
         align_err <= misalign;
         if (wr_last) begin
            wr_bank <= ~wr_bank;
         end
         if (load) begin
            // Column order: codeword index is the fast counter, word index the slow one.
            out_data  <= mem[rd_bank][{rd_cw, rd_w}];
            out_valid <= 1'b1;
            out_sof   <= (rd_cw == '0) && (rd_w == '0);
            rd_cw     <= rd_cw + ID_AW'(1);
            if (rd_cw == ID_AW'(INTLV_DEPTH - 1)) begin
               rd_w <= rd_w + CW_AW'(1);
            end
            if (rd_last) begin
               rd_bank <= ~rd_bank;
               if (blk_cnt != 16'hFFFF) begin
                  blk_cnt <= blk_cnt + 16'd1;
               end
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_as6d_pcs_tx_interleaver_pingpong_buf.sv
// Directed bench for the TX ping-pong interleaver: a per-cycle vector table for the
// ordering case plus hand-written sequences for streaming, stalls, sof errors and flush.
module tb_as6d_pcs_tx_interleaver_pingpong_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [71:0] in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [71:0] out_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_ready;
   logic        align_err;
   logic [15:0] blk_cnt;

   always #5 clk = ~clk;

   as6d_pcs_tx_interleaver_pingpong_buf #(
      .DATA_WIDTH  (72),
      .CW_WORDS    (8),
      .INTLV_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_ready (out_ready),
      .align_err (align_err),
      .blk_cnt   (blk_cnt)
   );

   typedef struct {
      logic        in_valid;
      logic        in_sof;
      logic [71:0] in_data;
      logic        exp_in_ready;
      logic        exp_valid;
      logic        exp_sof;
      logic [71:0] exp_data;
      logic [15:0] exp_blk;
   } vec_t;

   vec_t        tbl [64];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [71:0] got [$];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Expected k-th output of a block: word k/4 of codeword k%4.
   function automatic logic [71:0] ilv(input logic [71:0] base, input int k);
      return base + 72'((k % 4) * 8 + k / 4);
   endfunction

   // One clock: log handshakes and check that a stalled word stays put.
   task automatic step();
      logic        hold_pend;
      logic [71:0] held_data;
      logic        held_sof;
      hold_pend = 1'b0;
      held_data = '0;
      held_sof  = 1'b0;
      if (out_valid && out_ready) got.push_back(out_data);
      if (out_valid && !out_ready && enable && rst_n) begin
         hold_pend = 1'b1;
         held_data = out_data;
         held_sof  = out_sof;
      end
      @(posedge clk);
      #1;
      if (hold_pend) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, held_data);
         chk("stall_sof", out_sof, held_sof);
      end
   endtask

   task automatic send(input logic [71:0] d, input logic sof, input bit rnd);
      int g;
      g        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      while (!in_ready && g < 500) begin
         step();
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         g++;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic drain(input int n, input bit rnd);
      int g;
      g = 0;
      while (got.size() < n && g < 2000) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         step();
         g++;
      end
      out_ready = 1'b1;
      repeat (4) step();
      chk("drain_count", 72'(got.size()), 72'(n));
   endtask

   task automatic chk_block(input string name, input logic [71:0] base, input int off);
      for (int k = 0; k < 32; k++) begin
         if (off + k < got.size()) chk(name, got[off + k], ilv(base, k));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] b0;
      logic        ir_drop;
      logic        gap;
      logic        seen;
      int          g;

      rst_n     = 1'b0;
      enable    = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sof", out_sof, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_align_err", align_err, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("idle_in_ready_dis", in_ready, 0);
      enable = 1'b1;
      #1;
      chk("idle_in_ready_en", in_ready, 1);

      // Ordering: one block, per-cycle expectations
      for (int c = 0; c < 64; c++) begin
         tbl[c].in_valid     = (c < 32);
         tbl[c].in_sof       = (c == 0);
         tbl[c].in_data      = (c < 32) ? 72'(c) : 72'd0;
         tbl[c].exp_in_ready = 1'b1;
         tbl[c].exp_valid    = (c >= 32);
         tbl[c].exp_sof      = (c == 32);
         tbl[c].exp_data     = (c >= 32) ? ilv(72'd0, c - 32) : 72'd0;
         tbl[c].exp_blk      = (c >= 63) ? 16'd1 : 16'd0;
      end
      out_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 64; c++) begin
         in_valid = tbl[c].in_valid;
         in_sof   = tbl[c].in_sof;
         in_data  = tbl[c].in_data;
         chk("ord_in_ready", in_ready, tbl[c].exp_in_ready);
         step();
         chk("ord_out_valid", out_valid, tbl[c].exp_valid);
         chk("ord_out_sof", out_sof, tbl[c].exp_sof);
         chk("ord_out_data", out_data, tbl[c].exp_data);
         chk("ord_align_err", align_err, 0);
         chk("ord_blk_cnt", blk_cnt, tbl[c].exp_blk);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      step();
      step();
      $display("ordering: 32 words in, %0d words out, blk_cnt=%0d", got.size(), blk_cnt);

      // Streaming: three blocks back-to-back
      got.delete();
      b0      = blk_cnt;
      ir_drop = 1'b0;
      gap     = 1'b0;
      seen    = 1'b0;
      for (int i = 0; i < 96; i++) begin
         in_valid = 1'b1;
         in_data  = 72'h100 * 72'(i / 32 + 1) + 72'(i % 32);
         in_sof   = (i % 32 == 0);
         if (!in_ready) ir_drop = 1'b1;
         if (seen && !out_valid) gap = 1'b1;
         if (out_valid) seen = 1'b1;
         step();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      g = 0;
      while (got.size() < 96 && g < 300) begin
         if (seen && !out_valid) gap = 1'b1;
         if (out_valid) seen = 1'b1;
         step();
         g++;
      end
      repeat (4) step();
      chk("stream_in_ready_drop", ir_drop, 0);
      chk("stream_gap", gap, 0);
      chk("stream_count", 72'(got.size()), 72'd96);
      chk_block("stream_blk0", 72'h100, 0);
      chk_block("stream_blk1", 72'h200, 32);
      chk_block("stream_blk2", 72'h300, 64);
      chk("stream_blk_cnt", 16'(blk_cnt - b0), 3);
      $display("streaming: 96 words in, %0d words out, blk_cnt=%0d", got.size(), blk_cnt);

      // Backpressure: fill both banks with the output stalled
      out_ready = 1'b0;
      step();
      got.delete();
      b0      = blk_cnt;
      ir_drop = 1'b0;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         in_data  = 72'h1000 + 72'h100 * 72'(i / 32) + 72'(i % 32);
         in_sof   = (i % 32 == 0);
         if (!in_ready) ir_drop = 1'b1;
         step();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("bp_in_ready_drop", ir_drop, 0);
      chk("bp_in_ready_full", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 72'h1000);
      chk("bp_out_sof", out_sof, 1);
      repeat (3) step();
      out_ready = 1'b1;
      drain(64, 1'b0);
      chk_block("bp_blk0", 72'h1000, 0);
      chk_block("bp_blk1", 72'h1100, 32);
      chk("bp_blk_cnt", 16'(blk_cnt - b0), 2);
      $display("backpressure: 64 words in, %0d words out, blk_cnt=%0d", got.size(), blk_cnt);

      // Misaligned sof after 10 words
      got.delete();
      b0 = blk_cnt;
      for (int i = 0; i < 10; i++) send(72'h2000 + 72'(i), (i == 0), 1'b0);
      chk("mis_align_err_pre", align_err, 0);
      send(72'h2100, 1'b1, 1'b0);
      chk("mis_align_err_pulse", align_err, 1);
      for (int j = 1; j < 32; j++) begin
         send(72'h2100 + 72'(j), 1'b0, 1'b0);
         if (j == 1) chk("mis_align_err_clear", align_err, 0);
      end
      drain(32, 1'b0);
      chk_block("mis_blk", 72'h2100, 0);
      chk("mis_blk_cnt", 16'(blk_cnt - b0), 1);
      $display("misalign: 42 words in, %0d words out, blk_cnt=%0d", got.size(), blk_cnt);

      // Random out_ready
      got.delete();
      b0 = blk_cnt;
      for (int i = 0; i < 64; i++) begin
         send(72'h3000 + 72'h100 * 72'(i / 32) + 72'(i % 32), (i % 32 == 0), 1'b1);
      end
      drain(64, 1'b1);
      chk_block("rnd_blk0", 72'h3000, 0);
      chk_block("rnd_blk1", 72'h3100, 32);
      chk("rnd_blk_cnt", 16'(blk_cnt - b0), 2);
      $display("random_ready: 64 words in, %0d words out, blk_cnt=%0d", got.size(), blk_cnt);

      // Flush with a full bank stalled and a partial block pending
      out_ready = 1'b0;
      got.delete();
      for (int i = 0; i < 32; i++) send(72'h4000 + 72'(i), (i == 0), 1'b0);
      for (int i = 0; i < 12; i++) send(72'h4100 + 72'(i), (i == 0), 1'b0);
      step();
      chk("flush_pre_valid", out_valid, 1);
      b0     = blk_cnt;
      enable = 1'b0;
      step();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_out_sof", out_sof, 0);
      chk("flush_in_ready", in_ready, 0);
      chk("flush_blk_cnt", blk_cnt, b0);
      enable = 1'b1;
      #1;
      chk("flush_in_ready_en", in_ready, 1);
      out_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 32; i++) send(72'h4200 + 72'(i), (i == 0), 1'b0);
      drain(32, 1'b0);
      chk_block("flush_blk", 72'h4200, 0);
      chk("flush_blk_cnt_after", 16'(blk_cnt - b0), 1);
      $display("flush: 32 words refilled, %0d words out, blk_cnt=%0d", got.size(), blk_cnt);

      // Asynchronous reset while a word is presented
      out_ready = 1'b0;
      for (int i = 0; i < 32; i++) send(72'h5000 + 72'(i), (i == 0), 1'b0);
      step();
      chk("areset_pre_valid", out_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_out_data", out_data, 0);
      chk("areset_blk_cnt", blk_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("areset_in_ready", in_ready, 1);
      chk("areset_idle_valid", out_valid, 0);
      $display("async_reset: out_valid=%0d blk_cnt=%0d", out_valid, blk_cnt);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
